l1_pmem_arbiter: RTL and testbench

- Shares one physical-memory/L2 line port between the L1 instruction cache and the L1 data cache.
- Each cache presents its own pmem-style read/write handshake. The block grants one requester at a time, registers that requester's address, data and command onto the shared port, and routes the line response back.
- Ties use round-robin, with one exception: a completed D-cache write-back keeps the grant preference, so the D-cache's following allocate read is not delayed by an I-cache miss.

---
 rtl/l1_pmem_arbiter_if.sv | 45 ++++
 rtl/l1_pmem_arbiter.sv | 96 +++++++++
 tb/tb_l1_pmem_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/l1_pmem_arbiter_if.sv
// Signal bundle around the L1 physical-memory arbiter: the I-cache and D-cache pmem ports
// on one side and the shared L2/memory line port on the other.
interface l1_pmem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
);
    logic                  i_pmem_read;
    logic [ADDR_WIDTH-1:0] i_pmem_addr;
    logic [LINE_WIDTH-1:0] i_pmem_rdata;
    logic                  i_pmem_resp;

    logic                  d_pmem_read;
    logic                  d_pmem_write;
    logic [ADDR_WIDTH-1:0] d_pmem_addr;
    logic [LINE_WIDTH-1:0] d_pmem_wdata;
    logic [LINE_WIDTH-1:0] d_pmem_rdata;
    logic                  d_pmem_resp;

    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [LINE_WIDTH-1:0] mem_wdata;
    logic [LINE_WIDTH-1:0] mem_rdata;
    logic                  mem_resp;

    // The arbiter serves the caches and drives the shared memory port.
    modport slave (
        input  i_pmem_read, i_pmem_addr,
        output i_pmem_rdata, i_pmem_resp,
        input  d_pmem_read, d_pmem_write, d_pmem_addr, d_pmem_wdata,
        output d_pmem_rdata, d_pmem_resp,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_resp
    );

    // The surrounding caches and memory, seen from outside the arbiter.
    modport master (
        output i_pmem_read, i_pmem_addr,
        input  i_pmem_rdata, i_pmem_resp,
        output d_pmem_read, d_pmem_write, d_pmem_addr, d_pmem_wdata,
        input  d_pmem_rdata, d_pmem_resp,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_resp
    );
endinterface

// File: rtl/l1_pmem_arbiter.sv
// Shares one memory line port between the L1 I-cache and D-cache: round-robin grants,
// registered command/address/data, and a D write-back that keeps priority for its allocate.
module l1_pmem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input logic               clk,
    input logic               rst,
    l1_pmem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t state;
    logic   last_d;

    logic i_req;
    logic d_req;
    logic d_wins;

    assign i_req  = bus.i_pmem_read;
    assign d_req  = bus.d_pmem_read | bus.d_pmem_write;
    assign d_wins = d_req && (!i_req || !last_d);

    // A completed D write clears last_d so the D-cache's allocate read wins the next tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            last_d        <= 1'b1;
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.mem_addr  <= {ADDR_WIDTH{1'b0}};
            bus.mem_wdata <= {LINE_WIDTH{1'b0}};
        end else begin
            case (state)
                IDLE: begin
                    if (d_wins) begin
                        state         <= GRANT_D;
                        bus.mem_addr  <= bus.d_pmem_addr;
                        bus.mem_wdata <= bus.d_pmem_wdata;
                        bus.mem_write <= bus.d_pmem_write;
                        bus.mem_read  <= !bus.d_pmem_write;
                    end else if (i_req) begin
                        state         <= GRANT_I;
                        bus.mem_addr  <= bus.i_pmem_addr;
                        bus.mem_write <= 1'b0;
                        bus.mem_read  <= 1'b1;
                    end
                end
                GRANT_I: begin
                    if (bus.mem_resp) begin
                        state         <= IDLE;
                        last_d        <= 1'b0;
                        bus.mem_read  <= 1'b0;
                        bus.mem_write <= 1'b0;
                    end
                end
                GRANT_D: begin
                    if (bus.mem_resp) begin
                        state         <= IDLE;
                        last_d        <= !bus.mem_write;
                        bus.mem_read  <= 1'b0;
                        bus.mem_write <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.mem_read  <= 1'b0;
                    bus.mem_write <= 1'b0;
                end
            endcase
        end
    end

    // The response is forwarded in the completion cycle and only to the granted cache.
    always_comb begin
        bus.i_pmem_resp  = 1'b0;
        bus.i_pmem_rdata = {LINE_WIDTH{1'b0}};
        bus.d_pmem_resp  = 1'b0;
        bus.d_pmem_rdata = {LINE_WIDTH{1'b0}};
        if (bus.mem_resp) begin
            if (state == GRANT_I) begin
                bus.i_pmem_resp  = 1'b1;
                bus.i_pmem_rdata = bus.mem_rdata;
            end else if (state == GRANT_D) begin
                bus.d_pmem_resp  = 1'b1;
                bus.d_pmem_rdata = bus.mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_l1_pmem_arbiter.sv
// Randomized bench for l1_pmem_arbiter: random cache requests, memory latency and resets,
// checked every cycle against a port-ownership model of the arbitration rules.
module tb_l1_pmem_arbiter;

    localparam int AW         = 32;
    localparam int LW         = 256;
    localparam int NUM_CYCLES = 4000;

    logic clk;
    logic rst;

    l1_pmem_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

    l1_pmem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount  = 0;
    int curCycle   = 0;

    // Reference model: who owns the shared port, what it is doing, and who wins the next tie.
    int          owner;
    bit          portRead;
    bit          portWrite;
    logic [AW-1:0] portAddr;
    logic [LW-1:0] portWdata;
    bit          tieGoesToD;

    bit          iActive, iDone;
    logic [AW-1:0] iAddr;
    bit          dActive, dDone, dRd, dWr;
    logic [AW-1:0] dAddr;
    logic [LW-1:0] dWdata;
    int          rstHold;

    function automatic logic [LW-1:0] rand256();
        logic [LW-1:0] r;
        for (int k = 0; k < LW / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [LW-1:0] observed,
                               input logic [LW-1:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s cycle %0d: observed %h expected %h",
                      tag, curCycle, observed, expected);
    endtask

    task automatic modelReset();
        owner      = 0;
        portRead   = 1'b0;
        portWrite  = 1'b0;
        portAddr   = '0;
        portWdata  = '0;
        tieGoesToD = 1'b0;
    endtask

    // Advance the model across one rising edge using this cycle's inputs.
    task automatic modelStep();
        bit iWants;
        bit dWants;
        iWants = bus.i_pmem_read;
        dWants = bus.d_pmem_read || bus.d_pmem_write;
        if (owner == 0) begin
            if (dWants && (!iWants || tieGoesToD)) begin
                owner     = 2;
                portAddr  = bus.d_pmem_addr;
                portWdata = bus.d_pmem_wdata;
                portWrite = bus.d_pmem_write;
                portRead  = !bus.d_pmem_write;
            end else if (iWants) begin
                owner     = 1;
                portAddr  = bus.i_pmem_addr;
                portRead  = 1'b1;
                portWrite = 1'b0;
            end
        end else if (bus.mem_resp) begin
            // After I: D is next in line. After a D read: I. After a D write-back: D again.
            tieGoesToD = (owner == 1) ? 1'b1 : portWrite;
            owner      = 0;
            portRead   = 1'b0;
            portWrite  = 1'b0;
        end
    endtask

    task automatic applyStimulus(input int cyc);
        int kind;
        if (cyc < 2) rst = 1'b0;
        else if (rstHold > 0) begin
            rstHold--;
            rst = 1'b0;
        end else if ($urandom_range(0, 149) == 0) begin
            rstHold = $urandom_range(0, 1);
            rst     = 1'b0;
        end else rst = 1'b1;

        if (iDone) iActive = 1'b0;
        else if (!iActive) begin
            if ($urandom_range(0, 9) < 4) begin
                iActive = 1'b1;
                iAddr   = $urandom;
            end
        end else if ($urandom_range(0, 99) < 2) iActive = 1'b0;

        if (dDone) dActive = 1'b0;
        else if (!dActive) begin
            if ($urandom_range(0, 9) < 4) begin
                dActive = 1'b1;
                dAddr   = $urandom;
                dWdata  = rand256();
                kind    = $urandom_range(0, 9);
                dRd     = (kind < 5) || (kind == 9);
                dWr     = (kind >= 5);
            end
        end else if ($urandom_range(0, 99) < 2) dActive = 1'b0;

        bus.i_pmem_read  = iActive;
        bus.i_pmem_addr  = iActive ? iAddr : AW'($urandom);
        bus.d_pmem_read  = dActive && dRd;
        bus.d_pmem_write = dActive && dWr;
        bus.d_pmem_addr  = dActive ? dAddr : AW'($urandom);
        bus.d_pmem_wdata = dActive ? dWdata : rand256();
        bus.mem_resp     = (owner != 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 9) == 0);
        bus.mem_rdata    = rand256();
    endtask

    initial begin
        logic [LW-1:0] expIRdata, expDRdata;
        bit expIResp, expDResp;
        rst = 1'b0;
        bus.i_pmem_read = 1'b0;  bus.i_pmem_addr = '0;
        bus.d_pmem_read = 1'b0;  bus.d_pmem_write = 1'b0;
        bus.d_pmem_addr = '0;    bus.d_pmem_wdata = '0;
        bus.mem_rdata = '0;      bus.mem_resp = 1'b0;
        iActive = 0; iDone = 0; dActive = 0; dDone = 0; rstHold = 0;
        modelReset();

        for (int cyc = 0; cyc < NUM_CYCLES; cyc++) begin
            @(negedge clk);
            curCycle = cyc;
            applyStimulus(cyc);
            #1;
            if (!rst) modelReset();

            expIResp  = rst && owner == 1 && bus.mem_resp;
            expDResp  = rst && owner == 2 && bus.mem_resp;
            expIRdata = expIResp ? bus.mem_rdata : '0;
            expDRdata = expDResp ? bus.mem_rdata : '0;

            checkOutput("mem_read",     LW'(bus.mem_read),    LW'(portRead));
            checkOutput("mem_write",    LW'(bus.mem_write),   LW'(portWrite));
            checkOutput("mem_addr",     LW'(bus.mem_addr),    LW'(portAddr));
            checkOutput("mem_wdata",    bus.mem_wdata,        portWdata);
            checkOutput("i_pmem_resp",  LW'(bus.i_pmem_resp), LW'(expIResp));
            checkOutput("i_pmem_rdata", bus.i_pmem_rdata,     expIRdata);
            checkOutput("d_pmem_resp",  LW'(bus.d_pmem_resp), LW'(expDResp));
            checkOutput("d_pmem_rdata", bus.d_pmem_rdata,     expDRdata);

            iDone = expIResp;
            dDone = expDResp;
            if (rst) modelStep();
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
